drp_target_regfile: RTL and testbench



---
 rtl/drp_target_regfile_if.sv | 12 +
 rtl/drp_target_regfile.sv | 147 ++++++++++++++
 tb/tb_drp_target_regfile.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/drp_target_regfile_if.sv
// rtl/drp_target_regfile_if.sv - DRP port bundle between a DRP master and a target.
interface drp_target_regfile_if;
   logic        drp_en;
   logic        drp_we;
   logic [8:0]  drp_addr;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_rdy;

   modport master (output drp_en, drp_we, drp_addr, drp_di, input drp_do, drp_rdy);
   modport slave  (input drp_en, drp_we, drp_addr, drp_di, output drp_do, drp_rdy);
endinterface

// File: rtl/drp_target_regfile.sv
// rtl/drp_target_regfile.sv - DRP target with soft R/W registers and a saturating event counter.
module drp_target_regfile #(
   parameter int NUM_REGS = 16,
   parameter int LATENCY  = 2
) (
   input  logic                     drp_clk,
   input  logic                     rst_n,
   drp_target_regfile_if.slave      drp,
   input  logic                     err_inc,
   output logic [16*NUM_REGS-1:0]   reg_out,
   output logic                     protocol_err
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [8:0]  addr_q, addr_d;
   logic [15:0] di_q, di_d;
   logic        rdy_q, rdy_d;
   logic [15:0] do_q, do_d;
   logic        perr_q, perr_d;
   logic [15:0] regs_q [NUM_REGS];
   logic [15:0] regs_d [NUM_REGS];
   logic [31:0] evt_q, evt_d;
   logic [15:0] shadow_q, shadow_d;

   logic        exec;
   logic        ex_we;
   logic [8:0]  ex_addr;
   logic [15:0] ex_di;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      di_d    = di_q;
      perr_d  = 1'b0;
      exec    = 1'b0;
      ex_we   = we_q;
      ex_addr = addr_q;
      ex_di   = di_q;
      case (state_q)
         IDLE: begin
            if (drp.drp_en) begin
               // A single-cycle latency executes straight off the request strobe.
               if (LATENCY == 1) begin
                  exec    = 1'b1;
                  ex_we   = drp.drp_we;
                  ex_addr = drp.drp_addr;
                  ex_di   = drp.drp_di;
               end else begin
                  state_d = BUSY;
                  cnt_d   = LAT_M1;
                  we_d    = drp.drp_we;
                  addr_d  = drp.drp_addr;
                  di_d    = drp.drp_di;
               end
            end
         end
         BUSY: begin
            perr_d = drp.drp_en;
            if (cnt_q == 4'd1) begin
               exec    = 1'b1;
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      evt_d    = (err_inc && evt_q != 32'hFFFF_FFFF) ? evt_q + 32'd1 : evt_q;
      shadow_d = shadow_q;
      regs_d   = regs_q;
      rdy_d    = exec;
      do_d     = 16'h0000;
      if (exec) begin
         if (ex_we) begin
            // Clear beats a same-edge increment.
            if (ex_addr == 9'h102) begin
               evt_d    = 32'd0;
               shadow_d = 16'h0000;
            end
            for (int k = 0; k < NUM_REGS; k++) begin
               if (ex_addr == 9'(k)) regs_d[k] = ex_di;
            end
         end else begin
            case (ex_addr)
               9'h100: begin
                  do_d     = evt_q[15:0];
                  shadow_d = evt_q[31:16];
               end
               9'h101: do_d = shadow_q;
               default: begin
                  for (int k = 0; k < NUM_REGS; k++) begin
                     if (ex_addr == 9'(k)) do_d = regs_q[k];
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge drp_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         addr_q   <= 9'd0;
         di_q     <= 16'h0000;
         rdy_q    <= 1'b0;
         do_q     <= 16'h0000;
         perr_q   <= 1'b0;
         evt_q    <= 32'd0;
         shadow_q <= 16'h0000;
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 16'h0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         di_q     <= di_d;
         rdy_q    <= rdy_d;
         do_q     <= do_d;
         perr_q   <= perr_d;
         evt_q    <= evt_d;
         shadow_q <= shadow_d;
         regs_q   <= regs_d;
      end
   end

   always_comb begin
      reg_out = '0;
      for (int k = 0; k < NUM_REGS; k++) reg_out[16*k +: 16] = regs_q[k];
   end

   assign drp.drp_rdy  = rdy_q;
   assign drp.drp_do   = do_q;
   assign protocol_err = perr_q;
endmodule

// File: tb/tb_drp_target_regfile.sv
// tb/tb_drp_target_regfile.sv - randomized model-checked bench for drp_target_regfile.
module tb_drp_target_regfile;
   localparam int NR    = 16;
   localparam int LAT_A = 2;
   localparam int LAT_B = 3;
   localparam longint unsigned CMAX = 64'h0000_0000_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a_inc = 1'b0;
   logic b_inc = 1'b0;
   logic [16*NR-1:0] a_reg_out, b_reg_out;
   logic a_perr, b_perr;

   drp_target_regfile_if a_if ();
   drp_target_regfile_if b_if ();

   drp_target_regfile #(.NUM_REGS(NR), .LATENCY(LAT_A)) dut_a (
      .drp_clk(clk), .rst_n(rst_n), .drp(a_if.slave),
      .err_inc(a_inc), .reg_out(a_reg_out), .protocol_err(a_perr));

   drp_target_regfile #(.NUM_REGS(NR), .LATENCY(LAT_B)) dut_b (
      .drp_clk(clk), .rst_n(rst_n), .drp(b_if.slave),
      .err_inc(b_inc), .reg_out(b_reg_out), .protocol_err(b_perr));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   longint unsigned mcnt;
   logic [15:0] mshadow;
   logic [15:0] mreg [NR];
   bit rand_inc = 1'b0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [255:0] model_regs();
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < NR; k++) r[16*k +: 16] = mreg[k];
      return r;
   endfunction

   task automatic model_reset();
      mcnt = 0;
      mshadow = 16'h0000;
      for (int k = 0; k < NR; k++) mreg[k] = 16'h0000;
   endtask

   // One clock: event counter model advances by the strobe seen on the edge.
   task automatic step();
      if (rand_inc) a_inc = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (a_inc) mcnt = (mcnt == CMAX) ? CMAX : mcnt + 1;
      @(negedge clk);
   endtask

   task automatic txn_a(input bit we, input logic [8:0] addr, input logic [15:0] di);
      longint unsigned pre;
      logic [15:0] exp_do;
      a_if.drp_en = 1'b1;
      a_if.drp_we = we;
      a_if.drp_addr = addr;
      a_if.drp_di = di;
      pre = mcnt;
      for (int l = 1; l <= LAT_A; l++) begin
         if (l == LAT_A) pre = mcnt;
         step();
         a_if.drp_en = 1'b0;
         a_if.drp_we = 1'($urandom);
         a_if.drp_addr = 9'($urandom);
         a_if.drp_di = 16'($urandom);
         if (l < LAT_A) chk("rdy_early", a_if.drp_rdy, 1'b0);
      end
      exp_do = 16'h0000;
      if (we) begin
         if (addr < NR) mreg[addr[3:0]] = di;
         else if (addr == 9'h102) begin
            mcnt = 0;
            mshadow = 16'h0000;
         end
      end else begin
         if (addr < NR) exp_do = mreg[addr[3:0]];
         else if (addr == 9'h100) begin
            exp_do = pre[15:0];
            mshadow = pre[31:16];
         end else if (addr == 9'h101) exp_do = mshadow;
      end
      chk("rdy", a_if.drp_rdy, 1'b1);
      chk($sformatf("do@%0h", addr), a_if.drp_do, exp_do);
      chk("reg_out", a_reg_out, model_regs());
      chk("perr_a", a_perr, 1'b0);
      step();
      chk("rdy_drop", a_if.drp_rdy, 1'b0);
      chk("do_drop", a_if.drp_do, 16'h0000);
   endtask

   initial begin
      logic [8:0] ra;
      a_if.drp_en = 0; a_if.drp_we = 0; a_if.drp_addr = 0; a_if.drp_di = 0;
      b_if.drp_en = 0; b_if.drp_we = 0; b_if.drp_addr = 0; b_if.drp_di = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_rdy", a_if.drp_rdy, 1'b0);
      chk("rst_do", a_if.drp_do, 16'h0000);
      chk("rst_regs", a_reg_out, '0);
      chk("rst_perr", a_perr, 1'b0);
      rst_n = 1'b1;
      step();

      txn_a(1'b1, 9'd3, 16'hA5C3);
      chk("reg3", a_reg_out[63:48], 16'hA5C3);
      txn_a(1'b0, 9'd3, 16'h0000);
      txn_a(1'b0, 9'h1FF, 16'h0000);
      txn_a(1'b1, 9'h0F0, 16'h1234);
      txn_a(1'b1, 9'h101, 16'h5555);

      a_inc = 1'b1;
      repeat (5) step();
      txn_a(1'b1, 9'h102, 16'hFFFF);
      a_inc = 1'b0;
      step();
      txn_a(1'b0, 9'h100, 16'h0000);
      chk("clr_count", a_if.drp_do, 16'h0000);

      force dut_a.evt_q = 32'hFFFF_FFFE;
      #1 release dut_a.evt_q;
      mcnt = 64'h0000_0000_FFFF_FFFE;
      a_inc = 1'b1;
      repeat (5) step();
      txn_a(1'b0, 9'h100, 16'h0000);
      txn_a(1'b0, 9'h101, 16'h0000);
      chk("sat_hi", mshadow, 16'hFFFF);

      txn_a(1'b1, 9'h102, 16'h0000);
      repeat (70000) step();
      txn_a(1'b0, 9'h100, 16'h0000);
      txn_a(1'b0, 9'h101, 16'h0000);
      a_inc = 1'b0;

      rand_inc = 1'b1;
      repeat (300) begin
         case ($urandom_range(0, 6))
            0, 1, 2: ra = 9'($urandom_range(0, NR - 1));
            3:       ra = 9'h100;
            4:       ra = 9'h101;
            5:       ra = ($urandom_range(0, 3) == 0) ? 9'h102 : 9'h100;
            default: ra = 9'($urandom);
         endcase
         txn_a(1'($urandom), ra, 16'($urandom));
      end
      rand_inc = 1'b0;
      a_inc = 1'b0;

      b_if.drp_en = 1'b1; b_if.drp_we = 1'b1; b_if.drp_addr = 9'd5; b_if.drp_di = 16'h1234;
      step();
      chk("b_perr_n1", b_perr, 1'b0);
      chk("b_rdy_n1", b_if.drp_rdy, 1'b0);
      b_if.drp_di = 16'hBEEF;
      step();
      chk("b_perr_n2", b_perr, 1'b1);
      chk("b_rdy_n2", b_if.drp_rdy, 1'b0);
      b_if.drp_en = 1'b0;
      step();
      chk("b_rdy_n3", b_if.drp_rdy, 1'b1);
      chk("b_perr_n3", b_perr, 1'b0);
      chk("b_reg5", b_reg_out[16*5 +: 16], 16'h1234);
      b_if.drp_en = 1'b1; b_if.drp_we = 1'b0; b_if.drp_addr = 9'd5;
      step();
      chk("b_rdy_n4", b_if.drp_rdy, 1'b0);
      chk("b_perr_n4", b_perr, 1'b0);
      b_if.drp_en = 1'b0;
      step();
      chk("b_rdy_n5", b_if.drp_rdy, 1'b0);
      step();
      chk("b_rdy_n6", b_if.drp_rdy, 1'b1);
      chk("b_do_n6", b_if.drp_do, 16'h1234);
      step();
      chk("b_rdy_n7", b_if.drp_rdy, 1'b0);
      chk("b_do_n7", b_if.drp_do, 16'h0000);

      a_if.drp_en = 1'b1; a_if.drp_we = 1'b1; a_if.drp_addr = 9'd0; a_if.drp_di = 16'hFFFF;
      step();
      a_if.drp_en = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mrst_rdy", a_if.drp_rdy, 1'b0);
      chk("mrst_do", a_if.drp_do, 16'h0000);
      chk("mrst_regs", a_reg_out, '0);
      chk("mrst_perr", a_perr, 1'b0);
      chk("mrst_regs_b", b_reg_out, '0);
      @(negedge clk);
      repeat (2) begin
         step();
         chk("mrst_no_rdy", a_if.drp_rdy, 1'b0);
      end
      rst_n = 1'b1;
      step();
      chk("mrst_reg0", a_reg_out, '0);
      txn_a(1'b0, 9'd0, 16'h0000);
      txn_a(1'b0, 9'h100, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
